// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : mul_div_unit
// Purpose : Multi-cycle multiply/divide unit with architectural HI/LO
//           registers; one shift-add / shift-subtract step per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_is_div;
    logic                 r_sign1;
    logic                 r_sign2;
    logic                 r_dbz_pend;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;

    logic                 w_signed;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic                 w_dbz_start;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_diff;
    logic                 w_fits;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    always_comb begin
        w_signed    = ~op_i[0];
        w_neg1      = w_signed & src1_i[WIDTH-1];
        w_neg2      = w_signed & src2_i[WIDTH-1];
        w_mag1      = w_neg1 ? -src1_i : src1_i;
        w_mag2      = w_neg2 ? -src2_i : src2_i;
        w_dbz_start = op_i[1] & (src2_i == '0);

        // Multiply: accumulator holds {partial product, remaining multiplier bits}
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};

        // Divide: accumulator holds {partial remainder, dividend/quotient bits}
        w_rem_sh    = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff      = w_rem_sh - {1'b0, r_b};
        w_fits      = ~w_diff[WIDTH];
        w_div_next  = {(w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_fits};

        w_prod      = (r_sign1 ^ r_sign2) ? -r_acc : r_acc;
        w_quot      = (r_sign1 ^ r_sign2) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem       = r_sign1 ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_count    <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_dbz <= 1'b0;
                    if (wr_hi_i) r_hi <= wr_data_i;
                    if (wr_lo_i) r_lo <= wr_data_i;
                    if (start_i) begin
                        r_is_div <= op_i[1];
                        r_b      <= w_mag2;
                        r_count  <= c_CNT_W'(WIDTH);
                        r_busy   <= 1'b1;
                        if (w_dbz_start) begin
                            // Keep the raw dividend; it becomes HI unchanged
                            r_sign1    <= 1'b0;
                            r_sign2    <= 1'b0;
                            r_acc      <= {{WIDTH{1'b0}}, src1_i};
                            r_dbz_pend <= 1'b1;
                            r_state    <= S_FINISH;
                        end else begin
                            r_sign1    <= w_neg1;
                            r_sign2    <= w_neg2;
                            r_acc      <= {{WIDTH{1'b0}}, w_mag1};
                            r_dbz_pend <= 1'b0;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_acc   <= r_is_div ? w_div_next : w_mul_next;
                    r_count <= r_count - c_CNT_W'(1);
                    if (r_count == c_CNT_W'(1)) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    if (r_dbz_pend) begin
                        r_hi  <= r_acc[WIDTH-1:0];
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi  <= w_rem;
                        r_lo  <= w_quot;
                        r_dbz <= 1'b0;
                    end else begin
                        r_hi  <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo  <= w_prod[WIDTH-1:0];
                        r_dbz <= 1'b0;
                    end
                    r_dbz_pend <= 1'b0;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign div_by_zero_o = r_dbz;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;

endmodule
`default_nettype wire
